npc_gen: RTL
============

Name: npc_gen

Overview:
- Next-PC generator for the MIPS datapath; the producer side of the fetch PC register's NPC input.
- Takes the current fetch PC back from that register, plus control-flow events from the D and M stages.
- Drives `npc`, which the PC register latches on every rising `clk`.
- Owns the sequential exception-return state: EPC, the EXL lock and the fetch address-error flag.

Parameters:
- EXC_VECTOR, 32'h0000_4180, handler entry address.
- RESET_PC, 32'h0000_3000, reset value of `epc`; matches the PC register reset value.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- pc_f  input  32  current fetch PC from the PC register.
- pc_d  input  32  PC of the instruction in D stage.
- stall  input  1  hazard stall; hold fetch PC.
- br_taken  input  1  D-stage branch resolved taken.
- br_imm  input  16  branch offset, in words.
- j_en  input  1  D-stage j/jal.
- j_index  input  26  jump index field.
- jr_en  input  1  D-stage jr/jalr.
- jr_target  input  32  forwarded rs value.
- exc_req  input  1  M-stage exception request.
- exc_pc  input  32  PC of the faulting instruction.
- exc_bd  input  1  faulting instruction sits in a branch delay slot.
- eret  input  1  M-stage eret.
- npc  output  32  next PC, combinational.
- flush  output  1  combinational; kill younger F/D/E instructions.
- epc  output  32  registered exception PC.
- exl  output  1  registered exception level.
- adel_f  output  1  registered; the last redirect fetched a misaligned address.

Behaviour:
- Reset values (on the clk edge while reset=1): epc=RESET_PC, exl=0, adel_f=0.
- npc during reset is don't-care, because the PC register overrides it.
- `npc` selection priority, evaluated combinationally each cycle:
  - exc_req: EXC_VECTOR.
  - eret: epc.
  - stall: pc_f (hold).
  - jr_en: jr_target.
  - j_en: {pc_d[31:28], j_index, 2'b00}.
  - br_taken: pc_d + 4 + (sign_ext(br_imm) << 2).
  - otherwise: pc_f + 4.
- Delay slot: control flow is resolved in D stage while the delay-slot instruction is in F. Consequently pc_f+4 has already been fetched as the slot and is never squashed by j/jr/br.
- All adds are 32-bit modulo 2^32; wrap-around at 0xFFFF_FFFC is silent.
- br_imm is sign-extended from bit 15. 0x8000 yields pc_d + 4 - 0x20000.
- More than one of jr_en/j_en/br_taken asserted is a decoder fault. The priority above still applies, with no error flag.
- `flush` = exc_req | eret (exc_req takes priority, but either one asserts flush).
- On a clk edge with exc_req=1 and exl=0:
  - epc <= exc_bd ? exc_pc - 4 : exc_pc.
  - exl <= 1.
- On a clk edge with exc_req=1 and exl=1 (nested exception): epc and exl hold, and npc still equals EXC_VECTOR.
- On a clk edge with eret=1 and exc_req=0: exl <= 0; epc holds.
- Simultaneous exc_req and eret: the exception wins and eret is dropped.
- Stall with exc_req or eret: stall is ignored; redirect and flush happen.
- adel_f:
  - Set to 1 on an edge where the selected source is jr, or eret returning to epc, and the target has bits [1:0] != 0.
  - Cleared to 0 on any other non-stalled edge.
  - Holds its value during stall.
- Reset asserted mid-exception, with exc_req high in the same cycle: reset wins. State returns to its reset values.

Test Plan:
- Reset sequence: hold reset 2 cycles, release, pc_f=0x3000, no events -> npc=0x3004, epc=0x3000, exl=0, adel_f=0.
- Branch: pc_d=0x3008, br_taken=1, br_imm=0xFFFE -> npc=0x3004. With br_imm=0x0003 -> npc=0x3018. With stall=1 also asserted -> npc=pc_f.
- Jumps: pc_d=0x3010, j_en=1, j_index=0x0000C40 -> npc=0x0000_3100. Then jr_en=1, jr_target=0x3202 -> npc=0x3202, and adel_f=1 after the edge, cleared after the next non-stalled edge.
- Exception in delay slot: exc_req=1, exc_pc=0x3024, exc_bd=1, exl=0 -> npc=0x4180, flush=1, and after the edge epc=0x3020, exl=1.
- Nested exception, then eret: second exc_req with exc_pc=0x4190 while exl=1 -> epc stays 0x3020. Then eret=1 -> npc=0x3020, flush=1, and exl=0 after the edge.
- Simultaneous exc_req+eret+stall with exl=0, exc_pc=0x3040, exc_bd=0 -> npc=0x4180, epc=0x3040, exl=1. Then reset asserted together with exc_req -> epc=0x3000, exl=0.

Source files
------------

// File: rtl/npc_gen_if.sv
// npc_gen_if: control-flow events into the next-PC generator and the PC/exception state it returns.
//   pc_f, pc_d           : fetch PC and D-stage PC
//   stall                : hold the fetch PC
//   br_taken, br_imm     : D-stage taken branch and its word offset
//   j_en, j_index        : D-stage j/jal and its index field
//   jr_en, jr_target     : D-stage jr/jalr and the forwarded rs value
//   exc_req, exc_pc,
//   exc_bd, eret         : M-stage exception request, faulting PC, delay-slot flag, eret
//   npc, flush           : next fetch PC and kill of younger F/D/E work
//   epc, exl, adel_f     : exception return PC, exception level, fetch address error
interface npc_gen_if;
    logic [31:0] pc_f;
    logic [31:0] pc_d;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_imm;
    logic        j_en;
    logic [25:0] j_index;
    logic        jr_en;
    logic [31:0] jr_target;
    logic        exc_req;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic        eret;
    logic [31:0] npc;
    logic        flush;
    logic [31:0] epc;
    logic        exl;
    logic        adel_f;
    modport master (
        output pc_f, pc_d, stall, br_taken, br_imm, j_en, j_index,
               jr_en, jr_target, exc_req, exc_pc, exc_bd, eret,
        input  npc, flush, epc, exl, adel_f
    );
    modport slave (
        input  pc_f, pc_d, stall, br_taken, br_imm, j_en, j_index,
               jr_en, jr_target, exc_req, exc_pc, exc_bd, eret,
        output npc, flush, epc, exl, adel_f
    );
endinterface

// File: rtl/npc_gen.sv
// npc_gen: next-PC selection for the fetch PC register, plus EPC/EXL/fetch-address-error state.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : npc_gen_if.slave, event inputs and npc/flush/epc/exl/adel_f outputs
module npc_gen #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000
) (
    input logic       clk,
    input logic       reset,
    npc_gen_if.slave  bus
);
    typedef enum logic {ST_USER, ST_EXL} state_t;
    state_t      state, state_nx;
    logic [31:0] epc_q, epc_nx;
    logic        adel_q, adel_nx;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic        do_eret;
    logic        hold;
    logic        jr_sel;
    assign br_tgt  = bus.pc_d + 32'd4 + {{14{bus.br_imm[15]}}, bus.br_imm, 2'b00};
    assign j_tgt   = {bus.pc_d[31:28], bus.j_index, 2'b00};
    // an exception always beats eret and stall
    assign do_eret = bus.eret & ~bus.exc_req;
    assign hold    = bus.stall & ~bus.exc_req & ~bus.eret;
    assign jr_sel  = bus.jr_en & ~bus.exc_req & ~bus.eret & ~bus.stall;
    assign bus.npc = bus.exc_req  ? EXC_VECTOR :
                     bus.eret     ? epc_q :
                     bus.stall    ? bus.pc_f :
                     bus.jr_en    ? bus.jr_target :
                     bus.j_en     ? j_tgt :
                     bus.br_taken ? br_tgt : bus.pc_f + 32'd4;
    assign bus.flush  = bus.exc_req | bus.eret;
    assign bus.epc    = epc_q;
    assign bus.exl    = (state == ST_EXL);
    assign bus.adel_f = adel_q;
    always_comb begin
        state_nx = state;
        epc_nx   = epc_q;
        adel_nx  = adel_q;
        // a nested exception leaves EPC pointing at the original fault
        if (bus.exc_req && state == ST_USER) begin
            state_nx = ST_EXL;
            epc_nx   = bus.exc_bd ? bus.exc_pc - 32'd4 : bus.exc_pc;
        end else if (do_eret) begin
            state_nx = ST_USER;
        end
        if (!hold)
            adel_nx = (jr_sel && bus.jr_target[1:0] != 2'b00) ||
                      (do_eret && epc_q[1:0] != 2'b00);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_USER;
            epc_q  <= RESET_PC;
            adel_q <= 1'b0;
        end else begin
            state  <= state_nx;
            epc_q  <= epc_nx;
            adel_q <= adel_nx;
        end
    end
endmodule
